// File: rtl/t07_spi_pkg.sv
// Shared constants and FSM state encoding for the SPI register loader.
package t07_spi_pkg;

  localparam logic [2:0] CMD_WRITE   = 3'b101;
  localparam int         FRAME_BITS  = 40;
  localparam int         HEADER_BITS = 8;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_DONE   = 3'd3,
    ST_DRAIN  = 3'd4
  } state_t;

endpackage

// File: rtl/t07_sync.sv
// Multi-flop synchronizer for one asynchronous SPI pin; reset value is per-pin.
module t07_sync
  import t07_spi_pkg::*;
#(
  parameter int   STAGES  = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic nrst,
  input  logic d,
  output logic q
);

  logic [STAGES-1:0] sync_r;

  // shift the pin through the synchronizer chain
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sync_r <= {STAGES{RST_VAL}};
    end else begin
      sync_r <= {sync_r[STAGES-2:0], d};
    end
  end

  assign q = sync_r[STAGES-1];

endmodule

// File: rtl/t07_spi_reg_loader.sv
// SPI mode-0 slave that receives 40-bit {cmd, addr, data} frames and commits
// write frames to an external register file interface.
module t07_spi_reg_loader
  import t07_spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        nrst,
  input  logic        sclk,
  input  logic        cs_n,
  input  logic        mosi,
  output logic [4:0]  spi_address,
  output logic [31:0] write_data,
  output logic        frame_valid,
  output logic        frame_error,
  output logic        busy,
  output logic [7:0]  frame_count
);

  localparam logic [5:0] HDR_LAST   = 6'(HEADER_BITS - 1);
  localparam logic [5:0] FRM_LAST   = 6'(FRAME_BITS - 1);
  localparam logic [1:0] FLUSH_DONE = 2'(SYNC_STAGES);

  logic sclk_s, cs_n_s, mosi_s;
  logic sclk_d_r, cs_n_d_r;
  logic [1:0] flush_r;
  logic armed_r;
  logic sclk_rise_s, cs_fall_s;

  state_t state_r, state_nxt_s;
  logic [5:0]  bit_cnt_r, bit_cnt_nxt_s;
  logic [39:0] shift_r, shift_nxt_s;
  logic        commit_s, error_s;

  logic [4:0]  spi_address_r;
  logic [31:0] write_data_r;
  logic        frame_valid_r, frame_error_r, busy_r;
  logic [7:0]  frame_count_r;

  t07_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (.clk(clk), .nrst(nrst), .d(sclk), .q(sclk_s));
  t07_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_cs_n (.clk(clk), .nrst(nrst), .d(cs_n), .q(cs_n_s));
  t07_sync #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_mosi (.clk(clk), .nrst(nrst), .d(mosi), .q(mosi_s));

  // edge history plus arming: a cs_n low already present at reset release
  // must not look like a falling edge once the synchronizer flushes
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      sclk_d_r <= 1'b0;
      cs_n_d_r <= 1'b1;
      flush_r  <= 2'd0;
      armed_r  <= 1'b0;
    end else begin
      sclk_d_r <= sclk_s;
      cs_n_d_r <= cs_n_s;
      if (flush_r != FLUSH_DONE) begin
        flush_r <= flush_r + 2'd1;
      end else begin
        flush_r <= flush_r;
      end
      if ((flush_r == FLUSH_DONE) && cs_n_s) begin
        armed_r <= 1'b1;
      end else begin
        armed_r <= armed_r;
      end
    end
  end

  assign sclk_rise_s = ~sclk_d_r & sclk_s;
  assign cs_fall_s   = armed_r & cs_n_d_r & ~cs_n_s;

  // frame FSM; cs_n high always wins over a coincident sclk edge
  always_comb begin
    state_nxt_s   = state_r;
    bit_cnt_nxt_s = bit_cnt_r;
    shift_nxt_s   = shift_r;
    commit_s      = 1'b0;
    error_s       = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (cs_fall_s) begin
          state_nxt_s   = ST_HEADER;
          bit_cnt_nxt_s = 6'd0;
        end else begin
          state_nxt_s = ST_IDLE;
        end
      end
      ST_HEADER, ST_DATA: begin
        if (cs_n_s) begin
          error_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else if (sclk_rise_s) begin
          shift_nxt_s   = {shift_r[38:0], mosi_s};
          bit_cnt_nxt_s = bit_cnt_r + 6'd1;
          if (bit_cnt_r == HDR_LAST) begin
            state_nxt_s = ST_DATA;
          end else if (bit_cnt_r == FRM_LAST) begin
            state_nxt_s = ST_DONE;
          end else begin
            state_nxt_s = state_r;
          end
        end else begin
          state_nxt_s = state_r;
        end
      end
      ST_DONE: begin
        if (cs_n_s) begin
          if (shift_r[39:37] == CMD_WRITE) begin
            commit_s = 1'b1;
          end else begin
            error_s = 1'b1;
          end
          state_nxt_s = ST_IDLE;
        end else if (sclk_rise_s) begin
          state_nxt_s = ST_DRAIN;
        end else begin
          state_nxt_s = ST_DONE;
        end
      end
      ST_DRAIN: begin
        if (cs_n_s) begin
          error_s     = 1'b1;
          state_nxt_s = ST_IDLE;
        end else begin
          state_nxt_s = ST_DRAIN;
        end
      end
      default: begin
        state_nxt_s = ST_IDLE;
      end
    endcase
  end

  // state, shift register and registered outputs
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state_r       <= ST_IDLE;
      bit_cnt_r     <= 6'd0;
      shift_r       <= 40'd0;
      spi_address_r <= 5'd0;
      write_data_r  <= 32'd0;
      frame_valid_r <= 1'b0;
      frame_error_r <= 1'b0;
      busy_r        <= 1'b0;
      frame_count_r <= 8'd0;
    end else begin
      state_r       <= state_nxt_s;
      bit_cnt_r     <= bit_cnt_nxt_s;
      shift_r       <= shift_nxt_s;
      frame_valid_r <= commit_s;
      frame_error_r <= error_s;
      busy_r        <= (state_nxt_s != ST_IDLE);
      if (commit_s) begin
        spi_address_r <= shift_r[36:32];
        write_data_r  <= shift_r[31:0];
        frame_count_r <= frame_count_r + 8'd1;
      end else begin
        spi_address_r <= spi_address_r;
        write_data_r  <= write_data_r;
        frame_count_r <= frame_count_r;
      end
    end
  end

  assign spi_address = spi_address_r;
  assign write_data  = write_data_r;
  assign frame_valid = frame_valid_r;
  assign frame_error = frame_error_r;
  assign busy        = busy_r;
  assign frame_count = frame_count_r;

endmodule

// File: tb/tb_t07_spi_reg_loader.sv
// Directed bench for t07_spi_reg_loader with a queue-based scoreboard of frame outcomes.
module tb_t07_spi_reg_loader;
  import t07_spi_pkg::*;

  logic        clk = 1'b0;
  logic        nrst, sclk, cs_n, mosi;
  logic [4:0]  spi_address;
  logic [31:0] write_data;
  logic        frame_valid, frame_error, busy;
  logic [7:0]  frame_count;

  always #5 clk = ~clk;

  t07_spi_reg_loader #(.SYNC_STAGES(2)) dut (
    .clk(clk), .nrst(nrst), .sclk(sclk), .cs_n(cs_n), .mosi(mosi),
    .spi_address(spi_address), .write_data(write_data),
    .frame_valid(frame_valid), .frame_error(frame_error),
    .busy(busy), .frame_count(frame_count)
  );

  typedef struct {
    logic        is_valid;
    logic [4:0]  addr;
    logic [31:0] data;
    logic [7:0]  cnt;
  } exp_t;

  exp_t exp_q[$];
  int n_assert = 0;
  int n_fail   = 0;
  int nv = 0, ne = 0, nboth = 0;
  int m_valid_total = 0;
  logic [4:0]  m_addr = 5'd0;
  logic [31:0] m_data = 32'd0;
  logic [7:0]  m_cnt  = 8'd0;

  // pulse monitor
  always @(negedge clk) begin
    if (frame_valid === 1'b1) nv++;
    if (frame_error === 1'b1) ne++;
    if (frame_valid === 1'b1 && frame_error === 1'b1) nboth++;
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input logic [2:0] cmd, input logic [4:0] addr,
                          input logic [31:0] data, input bit full);
    exp_t e;
    if (full && cmd == 3'b101) begin
      m_addr = addr;
      m_data = data;
      m_cnt  = m_cnt + 8'd1;
      m_valid_total++;
      e.is_valid = 1'b1;
    end else begin
      e.is_valid = 1'b0;
    end
    e.addr = m_addr;
    e.data = m_data;
    e.cnt  = m_cnt;
    exp_q.push_back(e);
  endtask

  task automatic shift_bits(input logic [39:0] f, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (i < 40) mosi = f[39-i];
      else        mosi = 1'b0;
      #40 sclk = 1'b1;
      #40 sclk = 1'b0;
    end
  endtask

  task automatic check_result();
    exp_t e;
    bit   seen;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin
      @(negedge clk);
      if (frame_valid === 1'b1 || frame_error === 1'b1) seen = 1'b1;
    end
    chk("pulse_seen", 64'(seen), 64'd1);
    chk("queue_size", 64'(exp_q.size()), 64'd1);
    if (exp_q.size() != 0) e = exp_q.pop_front();
    else e = '{1'b1, 5'd0, 32'd0, 8'd0};
    chk("frame_valid", 64'(frame_valid), 64'(e.is_valid));
    chk("frame_error", 64'(frame_error), 64'(!e.is_valid));
    chk("spi_address", 64'(spi_address), 64'(e.addr));
    chk("write_data",  64'(write_data),  64'(e.data));
    chk("frame_count", 64'(frame_count), 64'(e.cnt));
    chk("busy_after",  64'(busy), 64'd0);
    @(negedge clk);
    chk("valid_width", 64'(frame_valid), 64'd0);
    chk("error_width", 64'(frame_error), 64'd0);
  endtask

  task automatic send_frame(input logic [2:0] cmd, input logic [4:0] addr,
                            input logic [31:0] data, input int nbits);
    logic [39:0] f;
    f = {cmd, addr, data};
    push_exp(cmd, addr, data, nbits == 40);
    cs_n = 1'b0;
    #40;
    shift_bits(f, nbits);
    #40 cs_n = 1'b1;
    check_result();
    #40;
  endtask

  initial begin
    logic [39:0] f;
    int nv0, ne0;
    nrst = 1'b0; sclk = 1'b0; cs_n = 1'b1; mosi = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_address", 64'(spi_address), 64'd0);
    chk("rst_data",    64'(write_data),  64'd0);
    chk("rst_valid",   64'(frame_valid), 64'd0);
    chk("rst_error",   64'(frame_error), 64'd0);
    chk("rst_busy",    64'(busy),        64'd0);
    chk("rst_count",   64'(frame_count), 64'd0);
    nrst = 1'b1;
    repeat (6) @(negedge clk);
    chk("idle_busy", 64'(busy), 64'd0);

    // basic write, short frame, bad command
    send_frame(3'b101, 5'd3, 32'hDEADBEEF, 40);
    send_frame(3'b101, 5'd7, 32'h12345678, 20);
    send_frame(3'b010, 5'd9, 32'hCAFEF00D, 40);
    send_frame(3'b101, 5'd17, 32'hA5A5_5A5A, 40);

    // 41-bit frame parks in DRAIN until cs_n rises
    f = {3'b101, 5'd4, 32'h0BADCAFE};
    push_exp(3'b101, 5'd4, 32'h0BADCAFE, 1'b0);
    ne0 = ne; nv0 = nv;
    cs_n = 1'b0;
    #40;
    shift_bits(f, 41);
    #40;
    chk("drain_busy", 64'(busy), 64'd1);
    chk("drain_no_pulse", 64'((ne - ne0) + (nv - nv0)), 64'd0);
    cs_n = 1'b1;
    check_result();
    #40;

    // 40th sclk rise coincident with cs_n rise
    f = {3'b101, 5'd6, 32'h11112222};
    push_exp(3'b101, 5'd6, 32'h11112222, 1'b0);
    cs_n = 1'b0;
    #40;
    shift_bits(f, 39);
    mosi = f[0];
    #40;
    sclk = 1'b1;
    cs_n = 1'b1;
    check_result();
    sclk = 1'b0;
    #40;

    // reset mid-DATA with cs_n held low through release
    f = {3'b101, 5'd12, 32'h87654321};
    nv0 = nv; ne0 = ne;
    cs_n = 1'b0;
    #40;
    shift_bits(f, 20);
    @(negedge clk);
    nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("mid_rst_busy",  64'(busy), 64'd0);
    chk("mid_rst_addr",  64'(spi_address), 64'd0);
    chk("mid_rst_count", 64'(frame_count), 64'd0);
    nrst = 1'b1;
    repeat (12) @(negedge clk);
    chk("post_rst_busy",  64'(busy), 64'd0);
    chk("post_rst_valid", 64'(nv - nv0), 64'd0);
    chk("post_rst_error", 64'(ne - ne0), 64'd0);
    cs_n = 1'b1;
    repeat (6) @(negedge clk);
    chk("cs_rise_idle_busy", 64'(busy), 64'd0);
    chk("cs_rise_no_error",  64'(ne - ne0), 64'd0);
    m_addr = 5'd0; m_data = 32'd0; m_cnt = 8'd0;
    send_frame(3'b101, 5'd9, 32'h0F0F1234, 40);

    // 255 more frames: 256 commits since reset, count wraps to zero
    for (int i = 0; i < 255; i++) begin
      if (i == 254) send_frame(3'b101, 5'd31, 32'h00000001, 40);
      else          send_frame(3'b101, 5'(i), $urandom, 40);
    end
    chk("wrap_count", 64'(frame_count), 64'd0);
    chk("last_addr",  64'(spi_address), 64'd31);
    chk("last_data",  64'(write_data),  64'd1);

    repeat (10) @(negedge clk);
    chk("total_valid", 64'(nv), 64'(m_valid_total));
    chk("never_both",  64'(nboth), 64'd0);
    chk("queue_empty", 64'(exp_q.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
